// File: rtl/cve2_fp_pkg.sv
// Shared types for the FP write-back path: the buffered result entry and the
// write-port source selector.
package cve2_fp_pkg;

  localparam int unsigned FpDataWidth = 32;

  typedef struct packed {
    logic [4:0]             rd;
    logic [FpDataWidth-1:0] data;
  } fp_wb_entry_t;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_LSU,
    WB_FIFO,
    WB_FPU
  } fp_wb_src_e;

  // With 16 registers the upper address bit is meaningless, so it is forced to 0.
  function automatic logic [4:0] fp_reg_addr(logic [4:0] rd, bit rv32e);
    return rv32e ? {1'b0, rd[3:0]} : rd;
  endfunction

endpackage

// File: rtl/cve2_fp_wb_fifo.sv
// Small FIFO buffering FPU results that lose arbitration for the RF write port.
// Pointers carry a phase bit so full and empty are distinguishable at any depth.
module cve2_fp_wb_fifo
  import cve2_fp_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fp_wb_entry_t push_data_i,
  input  logic         pop_i,
  output fp_wb_entry_t head_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned IdxW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [IdxW:0] wr_ptr_q, wr_ptr_d;
  logic [IdxW:0] rd_ptr_q, rd_ptr_d;
  logic          push_ok, pop_ok;
  fp_wb_entry_t  mem_q [Depth];

  // Index wraps at Depth-1 and toggles the phase bit, so non-power-of-2 depths work.
  function automatic logic [IdxW:0] ptr_inc(logic [IdxW:0] p);
    if (p[IdxW-1:0] == IdxW'(Depth - 1)) begin
      return {~p[IdxW], {IdxW{1'b0}}};
    end
    return p + (IdxW + 1)'(1);
  endfunction

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                   (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign head_o  = mem_q[rd_ptr_q[IdxW-1:0]];

  // NOTE: always_comb assigns every output a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[IdxW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/cve2_fp_wb_arbiter.sv
// FP register-file write-back arbiter: merges LSU loads and FPU results onto one
// write port and keeps the per-register busy scoreboard used by decode.
module cve2_fp_wb_arbiter
  import cve2_fp_pkg::*;
#(
  parameter bit          RV32E     = 1'b0,
  parameter int unsigned DataWidth = FpDataWidth,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           issue_valid_i,
  input  logic [4:0]                     issue_rd_i,
  output logic                           issue_ready_o,
  input  logic [4:0]                     raddr_a_i,
  input  logic [4:0]                     raddr_b_i,
  input  logic [4:0]                     raddr_c_i,
  input  logic                           ruse_a_i,
  input  logic                           ruse_b_i,
  input  logic                           ruse_c_i,
  output logic                           hazard_o,
  input  logic                           lsu_valid_i,
  input  logic [4:0]                     lsu_rd_i,
  input  logic [DataWidth-1:0]           lsu_wdata_i,
  input  logic                           fpu_valid_i,
  output logic                           fpu_ready_o,
  input  logic [4:0]                     fpu_rd_i,
  input  logic [DataWidth-1:0]           fpu_wdata_i,
  output logic                           we_a_o,
  output logic [4:0]                     waddr_a_o,
  output logic [DataWidth-1:0]           wdata_a_o,
  output logic [(RV32E ? 16 : 32)-1:0]   busy_o
);

  localparam int unsigned AW      = RV32E ? 4 : 5;
  localparam int unsigned NumRegs = 2 ** AW;

  fp_wb_entry_t   lsu_entry, fpu_entry, fifo_head, sel_entry;
  fp_wb_src_e     src;
  logic           fifo_full, fifo_empty, fifo_push, fifo_pop, fpu_hs;
  logic           we_q;
  logic [4:0]     waddr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [NumRegs-1:0]   busy_q, busy_d;
  logic [AW-1:0]  issue_idx;
  logic           unused_addr_msb;

  assign lsu_entry = '{rd: lsu_rd_i, data: lsu_wdata_i};
  assign fpu_entry = '{rd: fpu_rd_i, data: fpu_wdata_i};

  // Ready depends only on FIFO occupancy, so a full FIFO stalls the FPU even while popping.
  assign fpu_ready_o = ~fifo_full;
  assign fpu_hs      = fpu_valid_i & ~fifo_full;

  always_comb begin
    src       = WB_NONE;
    sel_entry = fpu_entry;
    if (lsu_valid_i) begin
      src       = WB_LSU;
      sel_entry = lsu_entry;
    end else if (!fifo_empty) begin
      src       = WB_FIFO;
      sel_entry = fifo_head;
    end else if (fpu_valid_i) begin
      src       = WB_FPU;
      sel_entry = fpu_entry;
    end
  end

  assign fifo_pop  = (src == WB_FIFO);
  assign fifo_push = fpu_hs & (src != WB_FPU);

  cve2_fp_wb_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (fifo_push),
    .push_data_i (fpu_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q <= (src != WB_NONE);
      if (src != WB_NONE) begin
        waddr_q <= fp_reg_addr(sel_entry.rd, RV32E);
        wdata_q <= sel_entry.data;
      end
    end
  end

  assign issue_idx     = issue_rd_i[AW-1:0];
  assign issue_ready_o = ~busy_q[issue_idx];

  // Clear is applied before set so a same-edge issue to the written register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q[AW-1:0]] = 1'b0;
    if (issue_valid_i && issue_ready_o) busy_d[issue_idx] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign hazard_o = (ruse_a_i & busy_q[raddr_a_i[AW-1:0]]) |
                    (ruse_b_i & busy_q[raddr_b_i[AW-1:0]]) |
                    (ruse_c_i & busy_q[raddr_c_i[AW-1:0]]);

  assign unused_addr_msb = ^{issue_rd_i[4], raddr_a_i[4], raddr_b_i[4], raddr_c_i[4]};

  assign we_a_o    = we_q;
  assign waddr_a_o = waddr_q;
  assign wdata_a_o = wdata_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_cve2_fp_wb_arbiter.sv
// Bench for cve2_fp_wb_arbiter: directed scenarios plus random traffic, all
// compared each cycle against a queue-based model of the write-back rules.
module tb_cve2_fp_wb_arbiter;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  raddr_a, raddr_b, raddr_c;
  logic        ruse_a, ruse_b, ruse_c;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_wdata;
  logic        fpu_valid;
  logic [4:0]  fpu_rd;
  logic [31:0] fpu_wdata;

  logic        issue_ready, hazard, fpu_ready, we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] busy;

  logic        issue_ready_e, hazard_e, fpu_ready_e, we_e;
  logic [4:0]  waddr_e;
  logic [31:0] wdata_e;
  logic [15:0] busy_e;

  always #5 clk = ~clk;

  cve2_fp_wb_arbiter #(.RV32E(1'b0), .DataWidth(32), .FifoDepth(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .ruse_a_i(ruse_a), .ruse_b_i(ruse_b), .ruse_c_i(ruse_c), .hazard_o(hazard),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
    .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata),
    .we_a_o(we), .waddr_a_o(waddr), .wdata_a_o(wdata), .busy_o(busy)
  );

  cve2_fp_wb_arbiter #(.RV32E(1'b1), .DataWidth(32), .FifoDepth(DEPTH)) dut_e (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready_e),
    .raddr_a_i(raddr_a), .raddr_b_i(raddr_b), .raddr_c_i(raddr_c),
    .ruse_a_i(ruse_a), .ruse_b_i(ruse_b), .ruse_c_i(ruse_c), .hazard_o(hazard_e),
    .lsu_valid_i(lsu_valid), .lsu_rd_i(lsu_rd), .lsu_wdata_i(lsu_wdata),
    .fpu_valid_i(fpu_valid), .fpu_ready_o(fpu_ready_e), .fpu_rd_i(fpu_rd), .fpu_wdata_i(fpu_wdata),
    .we_a_o(we_e), .waddr_a_o(waddr_e), .wdata_a_o(wdata_e), .busy_o(busy_e)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending FPU results as a queue, busy flags as an array.
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  ent_t        m_q[$];
  bit          m_busy[32];
  bit          m_we;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  task automatic idle_inputs();
    issue_valid = 0; issue_rd = 0;
    raddr_a = 0; raddr_b = 0; raddr_c = 0;
    ruse_a = 0; ruse_b = 0; ruse_c = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_wdata = 0;
    fpu_valid = 0; fpu_rd = 0; fpu_wdata = 0;
  endtask

  // One clock: check combinational outputs against the model, advance the model
  // across the edge, then check the registered outputs.
  task automatic cycle();
    bit   rdy, iready, hz, hs, sel;
    ent_t nxt;
    #1;
    rdy    = (m_q.size() < DEPTH);
    iready = !m_busy[issue_rd];
    hz     = (ruse_a && m_busy[raddr_a]) || (ruse_b && m_busy[raddr_b]) ||
             (ruse_c && m_busy[raddr_c]);
    check("fpu_ready", 64'(fpu_ready), 64'(rdy));
    check("issue_ready", 64'(issue_ready), 64'(iready));
    check("hazard", 64'(hazard), 64'(hz));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hs  = fpu_valid && rdy;
      sel = 1'b1;
      nxt = '{rd: fpu_rd, data: fpu_wdata};
      if (lsu_valid) begin
        nxt = '{rd: lsu_rd, data: lsu_wdata};
        if (hs) m_q.push_back('{rd: fpu_rd, data: fpu_wdata});
      end else if (m_q.size() > 0) begin
        nxt = m_q.pop_front();
        if (hs) m_q.push_back('{rd: fpu_rd, data: fpu_wdata});
      end else if (!fpu_valid) begin
        sel = 1'b0;
      end
      if (m_we) m_busy[m_waddr] = 1'b0;
      if (issue_valid && iready) m_busy[issue_rd] = 1'b1;
      m_we = sel;
      if (sel) begin
        m_waddr = nxt.rd;
        m_wdata = nxt.data;
      end
    end
    #1;
    check("we", 64'(we), 64'(m_we));
    check("waddr", 64'(waddr), 64'(m_waddr));
    check("wdata", 64'(wdata), 64'(m_wdata));
    check("busy", 64'(busy), 64'(model_busy_vec()));
  endtask

  task automatic sync_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    check("reset_we", 64'(we), 64'd0);
    check("reset_waddr", 64'(waddr), 64'd0);
    check("reset_wdata", 64'(wdata), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_fpu_ready", 64'(fpu_ready), 64'd1);

    // Issue rd=3, FPU writes it a cycle later; hazard holds until the write edge.
    issue_valid = 1; issue_rd = 5'd3; ruse_a = 1; raddr_a = 5'd3;
    cycle();
    issue_valid = 0;
    check("t1_hazard_busy", 64'(hazard), 64'd1);
    fpu_valid = 1; fpu_rd = 5'd3; fpu_wdata = 32'h3F80_0000;
    cycle();
    fpu_valid = 0;
    check("t1_we", 64'(we), 64'd1);
    check("t1_waddr", 64'(waddr), 64'd3);
    check("t1_wdata", 64'(wdata), 64'h3F80_0000);
    check("t1_hazard_pending", 64'(hazard), 64'd1);
    cycle();
    check("t1_busy3_clear", 64'(busy[3]), 64'd0);
    check("t1_hazard_drop", 64'(hazard), 64'd0);
    ruse_a = 0;

    // LSU and FPU together with an empty FIFO: LSU first, FPU buffered then written.
    sync_reset();
    lsu_valid = 1; lsu_rd = 5'd5; lsu_wdata = 32'hAAAA_0005;
    fpu_valid = 1; fpu_rd = 5'd6; fpu_wdata = 32'hBBBB_0006;
    cycle();
    lsu_valid = 0; fpu_valid = 0;
    check("t2_lsu_waddr", 64'(waddr), 64'd5);
    check("t2_lsu_wdata", 64'(wdata), 64'hAAAA_0005);
    check("t2_ready", 64'(fpu_ready), 64'd1);
    cycle();
    check("t2_fpu_we", 64'(we), 64'd1);
    check("t2_fpu_waddr", 64'(waddr), 64'd6);
    check("t2_fpu_wdata", 64'(wdata), 64'hBBBB_0006);

    // LSU held 4 cycles while the FPU streams: two pushes fill the FIFO.
    sync_reset();
    for (int i = 0; i < 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(8 + i); lsu_wdata = 32'h1000 + i;
      fpu_valid = 1; fpu_rd = 5'(16 + ((i < 2) ? i : 2)); fpu_wdata = 32'h2000 + fpu_rd;
      cycle();
      if (i == 1) check("t3_full_ready", 64'(fpu_ready), 64'd0);
    end
    lsu_valid = 0;
    cycle();
    check("t3_first", 64'(waddr), 64'd16);
    cycle();
    check("t3_second", 64'(waddr), 64'd17);
    fpu_valid = 0;
    cycle();
    check("t3_third", 64'(waddr), 64'd18);
    check("t3_third_data", 64'(wdata), 64'h2012);

    // Write to non-busy r7 coinciding with a new issue to r7: set wins.
    sync_reset();
    fpu_valid = 1; fpu_rd = 5'd7; fpu_wdata = 32'h7777;
    cycle();
    fpu_valid = 0;
    issue_valid = 1; issue_rd = 5'd7;
    cycle();
    check("t4_busy7_set", 64'(busy[7]), 64'd1);
    check("t4_waw_stall", 64'(issue_ready), 64'd0);
    cycle();
    issue_valid = 0;

    // 16-register variant: address bit 4 dropped on write and scoreboard.
    sync_reset();
    issue_valid = 1; issue_rd = 5'd3;
    cycle();
    issue_valid = 0;
    check("t5_busy_e3", 64'(busy_e[3]), 64'd1);
    fpu_valid = 1; fpu_rd = 5'h13; fpu_wdata = 32'hE13;
    cycle();
    fpu_valid = 0;
    check("t5_we_e", 64'(we_e), 64'd1);
    check("t5_waddr_e", 64'(waddr_e), 64'h03);
    cycle();
    check("t5_busy_e3_clear", 64'(busy_e[3]), 64'd0);

    // Reset with two buffered entries and a write pending.
    sync_reset();
    issue_valid = 1; issue_rd = 5'd9;
    for (int i = 0; i < 2; i++) begin
      lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_wdata = 32'h3000 + i;
      fpu_valid = 1; fpu_rd = 5'(24 + i); fpu_wdata = 32'h4000 + i;
      cycle();
      issue_valid = 0;
    end
    check("t6_pre_we", 64'(we), 64'd1);
    check("t6_pre_full", 64'(fpu_ready), 64'd0);
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("t6_we", 64'(we), 64'd0);
    check("t6_ready", 64'(fpu_ready), 64'd1);
    check("t6_busy", 64'(busy), 64'd0);
    cycle();
    check("t6_no_stale_write", 64'(we), 64'd0);

    // Random traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst         = ($urandom_range(0, 79) == 0);
      issue_valid = $urandom_range(0, 1);
      issue_rd    = 5'($urandom);
      raddr_a     = 5'($urandom); raddr_b = 5'($urandom); raddr_c = 5'($urandom);
      ruse_a      = $urandom_range(0, 1);
      ruse_b      = $urandom_range(0, 1);
      ruse_c      = $urandom_range(0, 1);
      lsu_valid   = ($urandom_range(0, 2) == 0);
      lsu_rd      = 5'($urandom);
      lsu_wdata   = $urandom;
      fpu_valid   = $urandom_range(0, 1);
      fpu_rd      = 5'($urandom);
      fpu_wdata   = $urandom;
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
